// File: rtl/fredkin_mux_pipe.sv
// fredkin_mux_pipe: pipelined N:1 word multiplexer built only from Fredkin gates.
// The binary mux tree has one register stage per level. Every unselected operand bit
// (the R output of each gate) is carried down the pipe as garbage. The select (the
// P output of each level) is also carried down the pipe, so the datapath is reversible.

// fredkin_gate: controlled swap. When a=0, b passes to q and c passes to r.
// When a=1, the two inputs are swapped. The control input a passes through unchanged on p.
module fredkin_gate (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic p,
    output logic q,
    output logic r
);
    assign p = a;
    assign q = a ? c : b;
    assign r = a ? b : c;
endmodule

module fredkin_mux_pipe #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    localparam int NUM_IN = 1 << SEL_W,
    localparam int GARB_W = WIDTH * (NUM_IN - 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*NUM_IN-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic [GARB_W-1:0]       out_garbage
);

    // adv[k] is high when stage k loads this cycle.
    // adv[SEL_W] is high when the consumer side frees the last stage.
    logic [SEL_W:0]   adv;
    logic [SEL_W-1:0] stage_valid;

    // Ripple the advance condition from the output back to the input.
    // A stage can load when it is empty or when the stage after it moves on.
    always_comb begin
        adv        = '0;
        adv[SEL_W] = ~stage_valid[SEL_W-1] | out_ready;
        for (int k = SEL_W - 1; k >= 0; k--) begin
            adv[k] = ~stage_valid[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    genvar gi, gj;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : gen_stage
            localparam int NW_IN  = NUM_IN >> gi;             // words entering this level
            localparam int NW_OUT = NW_IN / 2;                // words leaving this level
            localparam int GATES  = NW_OUT * WIDTH;           // one gate per output bit
            localparam int GB_CUR = WIDTH * (NUM_IN - NW_OUT); // garbage held after this level

            logic                    src_valid;
            logic [WIDTH*NW_IN-1:0]  src_words;
            logic [SEL_W-1:0]        src_sel;

            logic [GATES-1:0]        q_vec;
            logic [GATES-1:0]        r_vec;
            // The select bit is threaded through the P output of every gate in the level.
            // The P output of the last gate becomes the select bit that is carried on.
            logic [GATES:0]          ctl;
            logic [SEL_W-1:0]        sel_next;
            logic [GB_CUR-1:0]       garb_next;

            logic                    valid_reg;
            logic [GATES-1:0]        words_reg;
            logic [SEL_W-1:0]        sel_reg;
            logic [GB_CUR-1:0]       garb_reg;

            if (gi == 0) begin : gen_src_in
                assign src_valid = in_valid;
                assign src_words = in_data;
                assign src_sel   = in_sel;
                assign garb_next = r_vec;
            end else begin : gen_src_prev
                assign src_valid = gen_stage[gi-1].valid_reg;
                assign src_words = gen_stage[gi-1].words_reg;
                assign src_sel   = gen_stage[gi-1].sel_reg;
                // This level's garbage sits above the garbage gathered by earlier levels.
                assign garb_next = {r_vec, gen_stage[gi-1].garb_reg};
            end

            assign ctl[0] = src_sel[gi];

            // Output word j is a mux of word 2j (select=0) and word 2j+1 (select=1).
            for (gj = 0; gj < GATES; gj++) begin : gen_gate
                localparam int PAIR = gj / WIDTH;
                localparam int BITN = gj % WIDTH;
                fredkin_gate u_gate (
                    .a (ctl[gj]),
                    .b (src_words[(2*PAIR)*WIDTH + BITN]),
                    .c (src_words[(2*PAIR+1)*WIDTH + BITN]),
                    .p (ctl[gj+1]),
                    .q (q_vec[gj]),
                    .r (r_vec[gj])
                );
            end

            // The select travels with the data. This level's bit comes back from the gate chain.
            always_comb begin
                sel_next     = src_sel;
                sel_next[gi] = ctl[GATES];
            end

            assign stage_valid[gi] = valid_reg;

            // Stage register. A bubble clears only the valid flag; the payload registers keep their old values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    words_reg <= '0;
                    sel_reg   <= '0;
                    garb_reg  <= '0;
                end else if (adv[gi]) begin
                    valid_reg <= src_valid;
                    if (src_valid) begin
                        words_reg <= q_vec;
                        sel_reg   <= sel_next;
                        garb_reg  <= garb_next;
                    end
                end
            end
        end
    endgenerate

    assign out_valid   = gen_stage[SEL_W-1].valid_reg;
    assign out_data    = gen_stage[SEL_W-1].words_reg;
    assign out_sel     = gen_stage[SEL_W-1].sel_reg;
    assign out_garbage = gen_stage[SEL_W-1].garb_reg;

endmodule
